// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: round-robin arbiter in which the winner owns its one-hot
// grant for a whole multi-cycle transaction.
// An owner releases on done, on request drop, or when it hits the fairness
// hold limit while someone else waits.
// A dead GAP cycle always separates two owners.
// Optional watchdog: define ARB_TIMEOUT_EN to force a release after TIMEOUT
// owned cycles and pulse to_err; without it to_err is tied low.
module rr_hold_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16,
   parameter int TIMEOUT  = 64,
   localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic [N-1:0]  done,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_id,
   output logic          busy,
   output logic          to_err
);

   // Hold counter must reach MAX_HOLD-1; it saturates at its all-ones value.
   localparam int HW        = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;

   if (N < 2 || N > 32 || MAX_HOLD < 0 || TIMEOUT < 1) begin : g_param_check
      $error("rr_hold_arbiter: parameter out of range");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_OWN  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [N-1:0]  grant_q, grant_d;
   logic [HW-1:0] hold_cnt_q, hold_cnt_d;

   logic [IW-1:0] win_idx;
   logic          win_found;
   logic [N-1:0]  win_onehot;
   int            scan_idx;

   logic          owner_done;
   logic          owner_req;
   logic          others_wait;
   logic          hold_hit;
   logic          wd_hit;
   logic          release_own;
   logic [IW-1:0] ptr_after_owner;

   // Pick the first requesting index at or above ptr, wrapping modulo N.
   // The scan runs downward so the last hit (the one closest to ptr) wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int i = N - 1; i >= 0; i--) begin
         scan_idx = int'(ptr_q) + i;
         if (scan_idx >= N) begin
            scan_idx = scan_idx - N;
         end
         if (req[IW'(scan_idx)]) begin
            win_found = 1'b1;
            win_idx   = IW'(scan_idx);
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_win_onehot
      assign win_onehot[gi] = (win_idx == IW'(gi));
   end

   assign owner_done  = done[owner_q];
   assign owner_req   = req[owner_q];
   assign others_wait = |(req & ~grant_q);
   assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt_q == HW'(HOLD_LAST)) && others_wait;

   // Pointer always moves past the owner, so a hold-limit release naturally
   // gives every other waiting requester priority over the previous owner.
   assign ptr_after_owner = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);

   assign release_own = owner_done | ~owner_req | hold_hit | wd_hit;

`ifdef ARB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);

   logic [WW-1:0] wd_cnt_q, wd_cnt_d;
   logic          to_err_q, to_err_d;

   assign wd_hit = (wd_cnt_q == WW'(TIMEOUT - 1));
   assign to_err = to_err_q;

   // Watchdog counter and its error pulse register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q <= '0;
         to_err_q <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         to_err_q <= to_err_d;
      end
   end
`else
   assign wd_hit = 1'b0;
   assign to_err = 1'b0;
`endif

   // State, pointer, owner and grant registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         owner_q    <= '0;
         grant_q    <= '0;
         hold_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         grant_q    <= grant_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   // Next-state logic: arbitrate in IDLE, hold and watch release in OWN,
   // one dead cycle in GAP.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      grant_d    = grant_q;
      hold_cnt_d = hold_cnt_q;
`ifdef ARB_TIMEOUT_EN
      wd_cnt_d   = wd_cnt_q;
      to_err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (win_found) begin
               grant_d    = win_onehot;
               owner_d    = win_idx;
               hold_cnt_d = '0;
`ifdef ARB_TIMEOUT_EN
               wd_cnt_d   = '0;
`endif
               state_d    = S_OWN;
            end
         end
         S_OWN: begin
            if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
`ifdef ARB_TIMEOUT_EN
            wd_cnt_d = wd_cnt_q + WW'(1);
`endif
            if (release_own) begin
               grant_d = '0;
               owner_d = '0;
               ptr_d   = ptr_after_owner;
               state_d = S_GAP;
`ifdef ARB_TIMEOUT_EN
               // Error only when the watchdog is the reason for the release.
               to_err_d = wd_hit & ~owner_done & owner_req & ~hold_hit;
`endif
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            grant_d = '0;
            owner_d = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   assign grant    = grant_q;
   assign grant_id = owner_q;
   assign busy     = (state_q == S_OWN);

endmodule
